// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the work-RAM bus arbiter: FSM state encodings,
// requester port IDs and default widths/timing.
package mem_bus_defs;

   localparam int DEF_DW      = 16;
   localparam int DEF_AW      = 16;
   localparam int DEF_RD_LAT  = 1;
   localparam int DEF_MAX_RUN = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic PORT_VIDEO = 1'b0;
   localparam logic PORT_CPU   = 1'b1;

endpackage

// File: rtl/arb_fair_pick.sv
// Winner selection between the video port (priority) and the CPU port,
// with a run counter that hands the bus to the CPU after MAX_RUN back-to-back
// video grants while the CPU is waiting.
module arb_fair_pick
   import mem_bus_defs::*;
#(
   parameter int MAX_RUN = DEF_MAX_RUN
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic arbitrate,
   output logic winner
);

   localparam int            CW      = $clog2(MAX_RUN + 1);
   localparam logic [CW-1:0] RUN_MAX = CW'(MAX_RUN);

   logic [CW-1:0] run_cnt;

   // Video wins unless the CPU is waiting and the video quota is used up.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      winner = PORT_CPU;
      if (req0 && !(req1 && run_cnt == RUN_MAX))
         winner = PORT_VIDEO;
   end

   // Count consecutive video grants taken while the CPU was waiting.
   always_ff @(posedge clk) begin
      // NOTE: state in always_ff is updated with <= so every register samples pre-edge values.
      if (reset)
         run_cnt <= '0;
      else if (arbitrate) begin
         if (winner == PORT_CPU || !req1)
            run_cnt <= '0;
         else if (run_cnt != RUN_MAX)
            run_cnt <= run_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the single-port work RAM. Port 0 is video fetch
// (priority), port 1 is the CPU data bus. Each access runs IDLE (arbitrate),
// optionally RD_WAIT (read latency), then DONE (one-cycle ack).
module mem_bus_arbiter
   import mem_bus_defs::*;
#(
   parameter int DW      = DEF_DW,
   parameter int AW      = DEF_AW,
   parameter int RD_LAT  = DEF_RD_LAT,
   parameter int MAX_RUN = DEF_MAX_RUN
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata,
   output logic          grant_id,
   output logic          busy
);

   // Latency counter preload; RD_LAT is limited to 1..3 so two bits suffice.
   localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

   state_t        state, state_nxt;
   logic [1:0]    lat_cnt, lat_nxt;
   logic          arbitrate, winner;
   logic          sel_we;
   logic [AW-1:0] sel_addr, addr_nxt;
   logic [DW-1:0] sel_wdata, wdata_nxt;
   logic          we_nxt, grant_nxt, ack0_nxt, ack1_nxt;

   assign arbitrate = (state == S_IDLE) && (m0_req || m1_req);

   arb_fair_pick #(
      .MAX_RUN (MAX_RUN)
   ) u_pick (
      .clk       (clk),
      .reset     (reset),
      .req0      (m0_req),
      .req1      (m1_req),
      .arbitrate (arbitrate),
      .winner    (winner)
   );

   assign sel_we    = (winner == PORT_CPU) ? m1_we    : m0_we;
   assign sel_addr  = (winner == PORT_CPU) ? m1_addr  : m0_addr;
   assign sel_wdata = (winner == PORT_CPU) ? m1_wdata : m0_wdata;

   // Read data is a straight pass-through; requesters only look at it on a read ack.
   assign rdata = ram_rdata;
   assign busy  = (state != S_IDLE);

   // Next-state and next-output decode for the access sequencer.
   always_comb begin
      state_nxt = state;
      lat_nxt   = lat_cnt;
      addr_nxt  = ram_addr;
      wdata_nxt = ram_wdata;
      grant_nxt = grant_id;
      we_nxt    = 1'b0;
      ack0_nxt  = 1'b0;
      ack1_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (arbitrate) begin
               grant_nxt = winner;
               addr_nxt  = sel_addr;
               wdata_nxt = sel_wdata;
               we_nxt    = sel_we;
               if (sel_we) begin
                  // Writes complete in the cycle the strobe is on the RAM.
                  state_nxt = S_DONE;
                  ack0_nxt  = (winner == PORT_VIDEO);
                  ack1_nxt  = (winner == PORT_CPU);
               end else begin
                  state_nxt = S_RD_WAIT;
                  lat_nxt   = LAT_INIT;
               end
            end
         end
         S_RD_WAIT: begin
            if (lat_cnt == 2'd0) begin
               state_nxt = S_DONE;
               ack0_nxt  = (grant_id == PORT_VIDEO);
               ack1_nxt  = (grant_id == PORT_CPU);
            end else begin
               lat_nxt = lat_cnt - 2'd1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and registered RAM-side/ack outputs; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         lat_cnt   <= 2'd0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
         grant_id  <= 1'b0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
      end else begin
         state     <= state_nxt;
         lat_cnt   <= lat_nxt;
         ram_addr  <= addr_nxt;
         ram_wdata <= wdata_nxt;
         ram_we    <= we_nxt;
         grant_id  <= grant_nxt;
         m0_ack    <= ack0_nxt;
         m1_ack    <= ack1_nxt;
      end
   end

endmodule
